// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the MIPS datapath (slave).
// The datapath supplies op/funct/zero; the controller returns strobes, mux selects and debug state.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_o
    );

    modport slave (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM plus ALU decoder: one datapath step per clock,
// FETCH -> DECODE -> per-class states -> FETCH, with illegal op/funct detection.
module multicycle_controller #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEXE = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e     state_q, state_d;
    logic       pcwrite, branch, is_bne, funct_known;
    logic [1:0] aluop;

    assign is_bne = (bus.op == OP_BNE) && SUPPORT_BNE;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        funct_known = 1'b1;
        case (bus.funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_known = 1'b1;
            default: funct_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        aluop          = 2'b00;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.illegal_op = 1'b0;
        bus.state_o    = state_q;

        case (state_q)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXE;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        if (SUPPORT_BNE) begin
                            state_d = S_BRANCH;
                        end else begin
                            bus.illegal_op = 1'b1;
                            state_d        = S_FETCH;
                        end
                    end
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b10;
                if (funct_known) begin
                    state_d = S_ALUWB;
                end else begin
                    bus.illegal_op = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b01;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEXE: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset presents FETCH mux selects with every strobe suppressed, aborting any instruction.
        if (reset) begin
            pcwrite        = 1'b0;
            branch         = 1'b0;
            aluop          = 2'b00;
            bus.iord       = 1'b0;
            bus.memwrite   = 1'b0;
            bus.irwrite    = 1'b0;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b0;
            bus.regwrite   = 1'b0;
            bus.alusrca    = 1'b0;
            bus.alusrcb    = 2'b01;
            bus.pcsrc      = 2'b00;
            bus.illegal_op = 1'b0;
            bus.state_o    = 4'd0;
        end

        case (aluop)
            2'b00: bus.alucontrol = 3'b010;
            2'b01: bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase

        bus.pcen = pcwrite | (branch & (bus.zero ^ is_bne));
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected per-cycle output records are queued
// as each instruction is driven and popped against both bne-enabled and bne-disabled instances.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus1 ();
    multicycle_controller_if bus0 ();

    multicycle_controller #(.SUPPORT_BNE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));
    multicycle_controller #(.SUPPORT_BNE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alu;
        logic       ill;
    } exp_t;

    exp_t obs1, obs0;
    assign obs1 = {bus1.state_o, bus1.pcen, bus1.iord, bus1.memwrite, bus1.irwrite, bus1.regdst,
                   bus1.memtoreg, bus1.regwrite, bus1.alusrca, bus1.alusrcb, bus1.pcsrc,
                   bus1.alucontrol, bus1.illegal_op};
    assign obs0 = {bus0.state_o, bus0.pcen, bus0.iord, bus0.memwrite, bus0.irwrite, bus0.regdst,
                   bus0.memtoreg, bus0.regwrite, bus0.alusrca, bus0.alusrcb, bus0.pcsrc,
                   bus0.alucontrol, bus0.illegal_op};

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   chk0;

    function automatic exp_t e(input logic [3:0] st, input logic pcen, iord, memwrite, irwrite,
                               input logic regdst, memtoreg, regwrite, alusrca,
                               input logic [1:0] srcb, psrc, input logic [2:0] alu, input logic ill);
        return {st, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                srcb, psrc, alu, ill};
    endfunction

    //                          st pc io mw ir rd mr rw sa  srcb   pcsrc  alu     ill
    function automatic exp_t x_rst();   return e(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0); endfunction
    function automatic exp_t x_fetch(); return e(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0); endfunction
    function automatic exp_t x_dec(input logic ill); return e(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ill); endfunction
    function automatic exp_t x_madr();  return e(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0); endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        bus1.op = op; bus1.funct = funct; bus1.zero = zero;
        bus0.op = op; bus0.funct = funct; bus0.zero = zero;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        exp_t x;
        #1;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got %h required a queued record", tag, obs1);
            return;
        end
        x = q.pop_front();
        assert (obs1 === x) else begin
            fails++;
            $error("FAIL %s dut1: got %h expected %h", tag, obs1, x);
        end
        if (chk0) begin
            tests++;
            assert (obs0 === x) else begin
                fails++;
                $error("FAIL %s dut0: got %h expected %h", tag, obs0, x);
            end
        end
    endtask

    task automatic check0(input string tag, input exp_t x);
        #1;
        tests++;
        assert (obs0 === x) else begin
            fails++;
            $error("FAIL %s dut0: got %h expected %h", tag, obs0, x);
        end
    endtask

    task automatic run(input string tag);
        while (q.size() > 0) begin
            check(tag);
            step();
        end
    endtask

    logic [5:0] rfunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ralu   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        chk0  = 1'b1;
        reset = 1'b1;
        drive(6'b000000, 6'b000000, 1'b0);
        #1;
        repeat (3) q.push_back(x_rst());
        run("reset_hold");
        reset = 1'b0;

        drive(6'b001000, 6'b000000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        q.push_back(e(10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
        run("addi");

        drive(6'b101011, 6'b011110, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0)); q.push_back(x_madr());
        q.push_back(e(5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        run("sw");

        drive(6'b100011, 6'b011110, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0)); q.push_back(x_madr());
        q.push_back(e(3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        q.push_back(e(4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0));
        run("lw");

        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, rfunct[i], 1'b0);
            q.push_back(x_fetch()); q.push_back(x_dec(0));
            q.push_back(e(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ralu[i], 0));
            q.push_back(e(7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
            run("rtype");
        end

        drive(6'b000000, 6'b000000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 1));
        run("bad_funct");

        drive(6'b111111, 6'b100000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(1));
        run("bad_op");

        drive(6'b000010, 6'b000000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0));
        run("jump");

        drive(6'b000100, 6'b000000, 1'b1);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
        run("beq_taken");

        drive(6'b000100, 6'b000000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
        run("beq_not_taken");

        // Abort a store in MEMWR: the write strobe must not appear while reset is high.
        drive(6'b101011, 6'b000000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0)); q.push_back(x_madr());
        run("sw_pre_abort");
        reset = 1'b1;
        q.push_back(x_rst());
        check("reset_in_memwr");
        step();
        reset = 1'b0;

        chk0 = 1'b0;
        drive(6'b000101, 6'b000000, 1'b0);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
        run("bne_taken");

        drive(6'b000101, 6'b000000, 1'b1);
        q.push_back(x_fetch()); q.push_back(x_dec(0));
        q.push_back(e(8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
        run("bne_not_taken");

        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(6'b000101, 6'b000000, 1'b0);
        check0("nobne_fetch", x_fetch());
        step();
        check0("nobne_decode", x_dec(1));
        step();
        check0("nobne_refetch", x_fetch());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
